// File: rtl/dca_matrix_lsu_arbiter.sv
// rtl/dca_matrix_lsu_arbiter.sv - round-robin arbiter sharing one matrix LSU between NUM_REQ requesters
`ifndef BW_DCA_MATRIX_LSU_INST
`define BW_DCA_MATRIX_LSU_INST 32
`endif

module dca_matrix_lsu_arbiter #(
   parameter int                  NUM_REQ    = 3,
   parameter int                  BW_INST    = `BW_DCA_MATRIX_LSU_INST,
   parameter int                  BW_ROW     = 64,
   parameter logic [NUM_REQ-1:0]  STORE_MASK = NUM_REQ'(3'b100)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   input  logic                          enable,
   output logic                          busy,
   output logic                          protocol_error,

   input  logic [NUM_REQ-1:0]            req_inst_valid,
   output logic [NUM_REQ-1:0]            req_inst_ready,
   input  logic [NUM_REQ*BW_INST-1:0]    req_inst_list,

   output logic                          lsu_inst_valid,
   input  logic                          lsu_inst_ready,
   output logic [BW_INST-1:0]            lsu_inst,
   input  logic                          lsu_done,

   input  logic                          lsu_load_wvalid,
   input  logic                          lsu_load_wlast,
   input  logic [BW_ROW-1:0]             lsu_load_wdata,
   output logic                          lsu_load_wready,

   output logic [NUM_REQ-1:0]            req_load_wvalid,
   output logic                          req_load_wlast,
   output logic [BW_ROW-1:0]             req_load_wdata,
   input  logic [NUM_REQ-1:0]            req_load_wready,

   input  logic [NUM_REQ-1:0]            req_store_rvalid,
   input  logic [NUM_REQ-1:0]            req_store_rlast,
   input  logic [NUM_REQ*BW_ROW-1:0]     req_store_rdata,
   output logic [NUM_REQ-1:0]            req_store_rready,

   output logic                          lsu_store_rvalid,
   output logic                          lsu_store_rlast,
   output logic [BW_ROW-1:0]             lsu_store_rdata,
   input  logic                          lsu_store_rready,

   output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

   localparam int GW = $clog2(NUM_REQ);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ISSUE     = 2'd1;
   localparam logic [1:0] ST_WAIT_DONE = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [GW-1:0]       grant_id_q, grant_id_d;
   logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
   logic                protocol_error_q, protocol_error_d;

   logic                arb_found;
   logic [GW-1:0]       arb_idx;
   logic [NUM_REQ-1:0]  grant_oh;
   logic                in_issue;
   logic                in_wait;
   logic                grant_is_store;
   logic                route_load;
   logic                route_store;

   // Adds an offset to a requester index, wrapping at NUM_REQ (offset < NUM_REQ).
   function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_REQ) begin
         s = s - NUM_REQ;
      end
      return GW'(s);
   endfunction

   // Cyclic priority search: first valid requester at or after rr_ptr.
   always_comb begin
      logic [GW-1:0] cand;
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      // Walk from the farthest candidate back to rr_ptr so the closest one wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = wrap_add(rr_ptr_q, k);
         if (req_inst_valid[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   // Decode the held grant and the routing mode it implies.
   always_comb begin
      grant_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_oh[i] = (grant_id_q == GW'(i));
      end
      in_issue       = (state_q == ST_ISSUE);
      in_wait        = (state_q == ST_WAIT_DONE);
      grant_is_store = |(grant_oh & STORE_MASK);
      route_load     = in_wait & ~grant_is_store;
      route_store    = in_wait & grant_is_store;
   end

   // Instruction path: present the granted requester's instruction while issuing.
   always_comb begin
      lsu_inst_valid = in_issue;
      lsu_inst       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (in_issue && grant_oh[i]) begin
            lsu_inst = req_inst_list[i*BW_INST +: BW_INST];
         end
      end
      req_inst_ready = {NUM_REQ{in_issue & lsu_inst_ready}} & grant_oh;
   end

   // Load stream: LSU rows fan out to the granted load requester only.
   always_comb begin
      req_load_wvalid = {NUM_REQ{route_load & lsu_load_wvalid}} & grant_oh;
      req_load_wlast  = route_load & lsu_load_wlast;
      req_load_wdata  = route_load ? lsu_load_wdata : '0;
      lsu_load_wready = route_load & |(req_load_wready & grant_oh);
   end

   // Store stream: the granted store requester's rows are muxed onto the LSU.
   always_comb begin
      lsu_store_rvalid = route_store & |(req_store_rvalid & grant_oh);
      lsu_store_rlast  = route_store & |(req_store_rlast & grant_oh);
      lsu_store_rdata  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (route_store && grant_oh[i]) begin
            lsu_store_rdata = req_store_rdata[i*BW_ROW +: BW_ROW];
         end
      end
      req_store_rready = {NUM_REQ{route_store & lsu_store_rready}} & grant_oh;
   end

   // Next-state logic: clear dominates, enable gates every transition.
   always_comb begin
      state_d          = state_q;
      grant_id_d       = grant_id_q;
      rr_ptr_d         = rr_ptr_q;
      protocol_error_d = protocol_error_q;
      if (clear) begin
         state_d          = ST_IDLE;
         grant_id_d       = '0;
         rr_ptr_d         = '0;
         protocol_error_d = 1'b0;
      end else if (enable) begin
         case (state_q)
            ST_IDLE: begin
               if (arb_found) begin
                  grant_id_d = arb_idx;
                  state_d    = ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (lsu_inst_ready) begin
                  state_d = ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (lsu_done) begin
                  state_d  = ST_IDLE;
                  rr_ptr_d = wrap_add(grant_id_q, 1);
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
         // A completion pulse with no instruction outstanding is a protocol violation.
         if (lsu_done && !in_wait) begin
            protocol_error_d = 1'b1;
         end
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         grant_id_q       <= '0;
         rr_ptr_q         <= '0;
         protocol_error_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         grant_id_q       <= grant_id_d;
         rr_ptr_q         <= rr_ptr_d;
         protocol_error_q <= protocol_error_d;
      end
   end

   assign busy           = (state_q != ST_IDLE);
   assign protocol_error = protocol_error_q;
   assign grant_id       = grant_id_q;

endmodule

// File: tb/tb_dca_matrix_lsu_arbiter.sv
// tb/tb_dca_matrix_lsu_arbiter.sv - scoreboard bench for dca_matrix_lsu_arbiter
module tb_dca_matrix_lsu_arbiter;

   localparam int NR = 3;
   localparam int BI = 32;
   localparam int BR = 64;

   typedef struct {
      logic [BI-1:0] inst;
      int            id;
   } inst_t;

   typedef struct {
      logic [BR-1:0] data;
      logic          last;
      logic [NR-1:0] vec;
   } row_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              clear;
   logic              enable;
   logic              busy;
   logic              protocol_error;
   logic [NR-1:0]     req_inst_valid;
   logic [NR-1:0]     req_inst_ready;
   logic [NR*BI-1:0]  req_inst_list;
   logic              lsu_inst_valid;
   logic              lsu_inst_ready;
   logic [BI-1:0]     lsu_inst;
   logic              lsu_done;
   logic              lsu_load_wvalid;
   logic              lsu_load_wlast;
   logic [BR-1:0]     lsu_load_wdata;
   logic              lsu_load_wready;
   logic [NR-1:0]     req_load_wvalid;
   logic              req_load_wlast;
   logic [BR-1:0]     req_load_wdata;
   logic [NR-1:0]     req_load_wready;
   logic [NR-1:0]     req_store_rvalid;
   logic [NR-1:0]     req_store_rlast;
   logic [NR*BR-1:0]  req_store_rdata;
   logic [NR-1:0]     req_store_rready;
   logic              lsu_store_rvalid;
   logic              lsu_store_rlast;
   logic [BR-1:0]     lsu_store_rdata;
   logic              lsu_store_rready;
   logic [1:0]        grant_id;

   int total = 0;
   int bad   = 0;

   inst_t inst_q[$];
   row_t  load_q[$];
   row_t  store_q[$];

   dca_matrix_lsu_arbiter #(
      .NUM_REQ    (NR),
      .BW_INST    (BI),
      .BW_ROW     (BR),
      .STORE_MASK (3'b100)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .clear            (clear),
      .enable           (enable),
      .busy             (busy),
      .protocol_error   (protocol_error),
      .req_inst_valid   (req_inst_valid),
      .req_inst_ready   (req_inst_ready),
      .req_inst_list    (req_inst_list),
      .lsu_inst_valid   (lsu_inst_valid),
      .lsu_inst_ready   (lsu_inst_ready),
      .lsu_inst         (lsu_inst),
      .lsu_done         (lsu_done),
      .lsu_load_wvalid  (lsu_load_wvalid),
      .lsu_load_wlast   (lsu_load_wlast),
      .lsu_load_wdata   (lsu_load_wdata),
      .lsu_load_wready  (lsu_load_wready),
      .req_load_wvalid  (req_load_wvalid),
      .req_load_wlast   (req_load_wlast),
      .req_load_wdata   (req_load_wdata),
      .req_load_wready  (req_load_wready),
      .req_store_rvalid (req_store_rvalid),
      .req_store_rlast  (req_store_rlast),
      .req_store_rdata  (req_store_rdata),
      .req_store_rready (req_store_rready),
      .lsu_store_rvalid (lsu_store_rvalid),
      .lsu_store_rlast  (lsu_store_rlast),
      .lsu_store_rdata  (lsu_store_rdata),
      .lsu_store_rready (lsu_store_rready),
      .grant_id         (grant_id)
   );

   always #5 clk = ~clk;

   function automatic logic [BI-1:0] inst_of(input int i);
      return 32'hC0DE_0000 + BI'(i) * 32'h111;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_issue();
      int n;
      n = 0;
      while (!lsu_inst_valid && n < 20) begin
         tick();
         n++;
      end
      total++;
      if (!lsu_inst_valid) begin
         bad++;
         $display("FAIL wait_issue: got lsu_inst_valid=0 expected 1 within 20 cycles");
      end
   endtask

   task automatic do_grant(input logic [NR-1:0] mask, input int id);
      inst_t it;
      it.inst = inst_of(id);
      it.id   = id;
      inst_q.push_back(it);
      req_inst_valid = mask;
      wait_issue();
      tick();
      req_inst_valid = '0;
   endtask

   task automatic pulse_done();
      repeat (2) tick();
      lsu_done = 1'b1;
      tick();
      lsu_done = 1'b0;
   endtask

   // Instruction scoreboard: every shared-port handshake consumes one expectation.
   always @(negedge clk) begin
      inst_t it;
      logic [NR-1:0] oh;
      if (!rst && lsu_inst_valid && lsu_inst_ready && enable) begin
         if (inst_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL inst_unexpected: got lsu_inst=%0h expected no handshake", lsu_inst);
         end else begin
            it = inst_q.pop_front();
            oh = '0;
            oh[it.id] = 1'b1;
            check("lsu_inst", 64'(lsu_inst), 64'(it.inst));
            check("grant_id", 64'(grant_id), 64'(it.id));
            check("req_inst_ready", 64'(req_inst_ready), 64'(oh));
         end
      end
      if (!rst && req_inst_ready != '0 && !(lsu_inst_valid && lsu_inst_ready)) begin
         total++;
         bad++;
         $display("FAIL stray_ready: got req_inst_ready=%0b expected 0", req_inst_ready);
      end
   end

   // Load-row scoreboard.
   always @(negedge clk) begin
      row_t r;
      if (!rst && (req_load_wvalid & req_load_wready) != '0) begin
         if (load_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL load_unexpected: got wvalid=%0b expected no row", req_load_wvalid);
         end else begin
            r = load_q.pop_front();
            check("load_wvalid", 64'(req_load_wvalid), 64'(r.vec));
            check("load_wdata", req_load_wdata, r.data);
            check("load_wlast", 64'(req_load_wlast), 64'(r.last));
         end
      end
   end

   // Store-row scoreboard.
   always @(negedge clk) begin
      row_t r;
      if (!rst && lsu_store_rvalid && lsu_store_rready) begin
         if (store_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL store_unexpected: got rdata=%0h expected no row", lsu_store_rdata);
         end else begin
            r = store_q.pop_front();
            check("store_rdata", lsu_store_rdata, r.data);
            check("store_rlast", 64'(lsu_store_rlast), 64'(r.last));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   r;
      int   cyc;
      inst_t it;
      row_t  rw;

      rst              = 1'b1;
      clear            = 1'b0;
      enable           = 1'b1;
      req_inst_valid   = '0;
      req_inst_list    = {inst_of(2), inst_of(1), inst_of(0)};
      lsu_inst_ready   = 1'b1;
      lsu_done         = 1'b0;
      lsu_load_wvalid  = 1'b0;
      lsu_load_wlast   = 1'b0;
      lsu_load_wdata   = '0;
      req_load_wready  = '0;
      req_store_rvalid = '0;
      req_store_rlast  = '0;
      req_store_rdata  = '0;
      lsu_store_rready = 1'b0;

      tick();
      tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_lsu_inst_valid", 64'(lsu_inst_valid), 64'd0);
      check("rst_grant_id", 64'(grant_id), 64'd0);
      check("rst_protocol_error", 64'(protocol_error), 64'd0);
      check("rst_req_inst_ready", 64'(req_inst_ready), 64'd0);
      rst = 1'b0;
      tick();

      // Round-robin with all requesters valid continuously.
      for (int n = 0; n < 4; n++) begin
         it.inst = inst_of(n % 3);
         it.id   = n % 3;
         inst_q.push_back(it);
      end
      req_inst_valid = 3'b111;
      for (int n = 0; n < 4; n++) begin
         wait_issue();
         tick();
         check("rr_busy_wait", 64'(busy), 64'd1);
         repeat (3) tick();
         lsu_done = 1'b1;
         tick();
         lsu_done = 1'b0;
         if (n == 3) begin
            req_inst_valid = '0;
         end
      end
      tick();
      check("rr_idle_after", 64'(busy), 64'd0);

      // Load routing to requester 1 with toggling downstream ready.
      do_grant(3'b010, 1);
      for (int k = 0; k < 8; k++) begin
         rw.data = 64'h1000 + 64'(k);
         rw.last = (k == 7);
         rw.vec  = 3'b010;
         load_q.push_back(rw);
      end
      r = 0;
      cyc = 0;
      while (r < 8 && cyc < 40) begin
         lsu_load_wvalid = 1'b1;
         lsu_load_wdata  = 64'h1000 + 64'(r);
         lsu_load_wlast  = (r == 7);
         req_load_wready = {1'b1, (cyc % 2 == 0), 1'b1};
         #1;
         check("load_wready_mirror", 64'(lsu_load_wready), 64'(req_load_wready[1]));
         check("load_wvalid_vec", 64'(req_load_wvalid), 64'(3'b010));
         check("load_store_idle", 64'(lsu_store_rvalid), 64'd0);
         tick();
         if (req_load_wready[1]) begin
            r++;
         end
         cyc++;
      end
      check("load_rows_done", 64'(r), 64'd8);
      lsu_load_wvalid = 1'b0;
      lsu_load_wlast  = 1'b0;
      pulse_done();

      // Store routing from requester 2 while requester 0 drives junk.
      do_grant(3'b100, 2);
      for (int k = 0; k < 8; k++) begin
         rw.data = 64'(k);
         rw.last = (k == 7);
         rw.vec  = 3'b100;
         store_q.push_back(rw);
      end
      r = 0;
      cyc = 0;
      lsu_load_wvalid = 1'b1;
      req_load_wready = 3'b111;
      while (r < 8 && cyc < 40) begin
         req_store_rvalid = 3'b101;
         req_store_rlast  = {(r == 7), 1'b0, 1'b1};
         req_store_rdata  = {64'(r), 64'h0, 64'hDEAD};
         lsu_store_rready = (cyc % 3 != 2);
         #1;
         check("store_load_wready", 64'(lsu_load_wready), 64'd0);
         check("store_no_load_valid", 64'(req_load_wvalid), 64'd0);
         check("store_rready_vec", 64'(req_store_rready), 64'({lsu_store_rready, 2'b00}));
         tick();
         if (lsu_store_rready) begin
            r++;
         end
         cyc++;
      end
      check("store_rows_done", 64'(r), 64'd8);
      req_store_rvalid = '0;
      req_store_rlast  = '0;
      lsu_store_rready = 1'b0;
      lsu_load_wvalid  = 1'b0;
      req_load_wready  = '0;
      pulse_done();

      // Stray completion while idle.
      check("perr_before", 64'(protocol_error), 64'd0);
      lsu_done = 1'b1;
      tick();
      lsu_done = 1'b0;
      check("perr_set", 64'(protocol_error), 64'd1);
      repeat (3) tick();
      check("perr_sticky", 64'(protocol_error), 64'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("perr_cleared", 64'(protocol_error), 64'd0);

      // Freeze in WAIT_DONE, then clear resets the round-robin pointer.
      do_grant(3'b001, 0);
      pulse_done();
      do_grant(3'b010, 1);
      enable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         lsu_done = (k == 2);
         tick();
         check("freeze_busy", 64'(busy), 64'd1);
         check("freeze_grant", 64'(grant_id), 64'd1);
         check("freeze_perr", 64'(protocol_error), 64'd0);
      end
      lsu_done = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear_busy", 64'(busy), 64'd0);
      check("clear_grant", 64'(grant_id), 64'd0);
      enable = 1'b1;
      do_grant(3'b101, 0);
      pulse_done();

      // Asynchronous reset in the middle of ISSUE.
      lsu_inst_ready = 1'b0;
      req_inst_valid = 3'b100;
      wait_issue();
      check("pre_rst_grant", 64'(grant_id), 64'd2);
      #2;
      rst = 1'b1;
      #1;
      check("arst_inst_valid", 64'(lsu_inst_valid), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_inst_ready", 64'(req_inst_ready), 64'd0);
      tick();
      rst = 1'b0;
      req_inst_valid = '0;
      lsu_inst_ready = 1'b1;
      tick();
      do_grant(3'b111, 0);
      pulse_done();

      repeat (3) tick();
      check("inst_q_empty", 64'(inst_q.size()), 64'd0);
      check("load_q_empty", 64'(load_q.size()), 64'd0);
      check("store_q_empty", 64'(store_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dca_matrix_lsu_arbiter.md
Name: dca_matrix_lsu_arbiter

Overview:
- Shares one matrix LSU between NUM_REQ matrix-register requesters, for example load-A, load-B and the load/store-C pipes of a DCA matrix MAC.
- Arbitrates LSU instructions round-robin and locks the grant until the LSU signals completion.
- While a grant is held, the tensor-row load stream is steered to the granted requester, and that requester's store stream is steered to the LSU.
- Sits between the per-operand instruction generators and the single shared LSU port.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- BW_INST, `BW_DCA_MATRIX_LSU_INST, LSU instruction width.
- BW_ROW, 64, tensor row width (BW_TENSOR_ROW of the instantiating core).
- STORE_MASK, 3'b100, bit i=1 means requester i is a store requester and its row stream is routed LSU-ward.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- clear  in  1  synchronous clear
- enable  in  1  advance enable; 0 freezes all state
- busy  out  1  state != IDLE
- protocol_error  out  1  sticky; set on lsu_done outside WAIT_DONE
- req_inst_valid  in  NUM_REQ  per-requester instruction valid
- req_inst_ready  out  NUM_REQ  per-requester instruction accept
- req_inst_list  in  NUM_REQ*BW_INST  flattened instructions; requester i at [i*BW_INST+:BW_INST]
- lsu_inst_valid  out  1  shared instruction valid
- lsu_inst_ready  in  1  shared instruction ready
- lsu_inst  out  BW_INST  shared instruction
- lsu_done  in  1  one-cycle completion pulse of the current LSU instruction
- lsu_load_wvalid/wlast  in  1/1  LSU load row stream
- lsu_load_wdata  in  BW_ROW
- lsu_load_wready  out  1
- req_load_wvalid  out  NUM_REQ  demuxed load valid
- req_load_wlast  out  1  broadcast
- req_load_wdata  out  BW_ROW  broadcast
- req_load_wready  in  NUM_REQ
- req_store_rvalid/rlast  in  NUM_REQ/NUM_REQ  store row streams
- req_store_rdata  in  NUM_REQ*BW_ROW
- req_store_rready  out  NUM_REQ
- lsu_store_rvalid/rlast  out  1/1
- lsu_store_rdata  out  BW_ROW
- lsu_store_rready  in  1
- grant_id  out  clog2(NUM_REQ)  current/last grant index

Behaviour:
- States: IDLE, ISSUE, WAIT_DONE.
  - Registers: state, grant_id, rr_ptr (next-priority index), protocol_error.
  - Reset values: IDLE, 0, 0, 0. All outputs are 0 in reset.
- IDLE, with enable=1 and any req_inst_valid:
  - grant_id <= first valid index at or after rr_ptr, searching cyclically.
  - Transition to ISSUE on the next edge.
  - Arbitration to lsu_inst_valid latency is 1 cycle.
- ISSUE:
  - lsu_inst_valid = 1 and lsu_inst = req_inst_list[grant_id]. Both are combinational from the held grant.
  - req_inst_ready[grant_id] = lsu_inst_ready; all other bits are 0.
  - On the handshake (valid & ready & enable), go to WAIT_DONE.
  - A requester drops valid only after the handshake; a drop beforehand is undefined.
- WAIT_DONE:
  - Streams are routed to grant_id.
  - If STORE_MASK[grant_id]=0:
    - req_load_wvalid[grant_id] = lsu_load_wvalid.
    - lsu_load_wready = req_load_wready[grant_id].
    - Store outputs are 0.
  - If STORE_MASK[grant_id]=1:
    - lsu_store_r* = req_store_r*[grant_id].
    - req_store_rready[grant_id] = lsu_store_rready.
    - lsu_load_wready = 0.
  - On lsu_done & enable: go to IDLE and set rr_ptr <= (grant_id+1) mod NUM_REQ.
- Outside WAIT_DONE, all routed valids and readies are 0. Data buses carry broadcast/mux values; these are don't-care.
- lsu_done is sampled only in WAIT_DONE. lsu_done & enable in IDLE or ISSUE sets protocol_error; it is cleared only by rst or clear.
- A new request arriving during ISSUE or WAIT_DONE waits. A grant is never preempted.
- With all requesters valid continuously, the grant order is 0,1,2,0,... The minimum period per instruction is 3 cycles plus LSU latency.
- enable=0: state, grant_id, rr_ptr and protocol_error hold. Combinational routing still reflects the held state, but no transitions occur.
- clear=1, which takes priority over enable: synchronous return to IDLE with rr_ptr=0, grant_id=0, protocol_error=0. An in-flight LSU operation is abandoned; the caller clears the LSU in the same cycle.
- rst asserted at any time: immediate return to reset values, with all valid/ready outputs low in the same cycle.

Test Plan:
- Round-robin: all three req_inst_valid=1 with distinct instructions, each lsu_done 4 cycles after acceptance -> lsu_inst sequence req0,req1,req2,req0. grant_id 0,1,2,0. Exactly one req_inst_ready pulse per accepted instruction.
- Load routing: grant req1 (load); LSU sends 8 rows with wlast on the 8th while req_load_wready[1] toggles 1,0,1 -> req_load_wvalid=3'b010 only. lsu_load_wready mirrors req_load_wready[1]. All 8 rows transfer.
- Store routing: grant req2 (STORE_MASK bit 2); req2 drives 8 rows with rdata=row index -> lsu_store_rdata 0..7 in order, rlast on row 7. lsu_load_wready=0 throughout.
- Stray done: lsu_done pulse in IDLE -> protocol_error=1 next cycle and held. clear pulse -> 0.
- Freeze/clear: enable=0 for 5 cycles in WAIT_DONE with lsu_done pulsed -> state unchanged and busy=1. Then clear -> busy=0 and rr_ptr=0; the next request from req2 with req0 also valid grants req0.
- Async reset: assert rst mid-ISSUE, between clock edges -> lsu_inst_valid=0, busy=0 before the next edge. After deassert, the first grant goes to index 0.
